// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, condition codes and NZCV flag bit positions.
package cpu_pkg;

    // ALU opcodes; 0000..1010 produce a register result
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for opcodes whose ALU result is defined and written to the register file
    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag nibble.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Full 16-entry decode of the condition field
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Write-back stage after the ALU: condition check, NZCV commit, one-entry
// valid/ready output register toward the register file, debug counters.
module alu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op_code,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [3:0]            in_flags,
    input  logic [3:0]            in_cond,
    input  logic                  in_s,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [3:0]            status_flags,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      skipped_cnt
);

    logic                  valid_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [3:0]            flags_q;
    logic [CNT_W-1:0]      retired_q;
    logic [CNT_W-1:0]      skipped_q;

    logic cond_pass;
    logic accept;
    logic writes;
    logic flag_update;

    // Condition is judged against the flags as they stand before this bundle
    cond_check u_cond_check (
        .cond  (in_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    assign in_ready    = !valid_q || out_ready;
    assign accept      = in_valid && in_ready && !flush;
    assign writes      = cond_pass && op_writes(in_op_code);
    assign flag_update = cond_pass && (in_s || (in_op_code == OP_CMP));

    // Output register: flush wins, then load on accept, else drain on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            wen_q   <= writes;
            addr_q  <= in_dest;
            // Non-writing ops may carry an undefined result; keep it off the data bus
            data_q  <= writes ? in_result : '0;
        end else if (out_ready) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
        end
    end

    // Architectural NZCV: committed on the accepting edge so the next bundle sees it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (accept && flag_update) begin
            flags_q <= in_flags;
        end
    end

    // Debug counters: every accepted bundle bumps exactly one of them, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            skipped_q <= '0;
        end else if (accept) begin
            if (cond_pass) begin
                retired_q <= retired_q + CNT_W'(1);
            end else begin
                skipped_q <= skipped_q + CNT_W'(1);
            end
        end
    end

    assign out_valid    = valid_q;
    assign wb_en        = wen_q && valid_q;
    assign wb_addr      = addr_q;
    assign wb_data      = data_q;
    assign status_flags = flags_q;
    assign retired_cnt  = retired_q;
    assign skipped_cnt  = skipped_q;

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU; captures the ALU result and flags each accepted instruction.
- Evaluates the 4-bit condition field against the architectural NZCV status register and commits flag updates.
- Drives the register-file write port through a one-entry valid/ready output register with stall support.
- Also keeps retired and skipped instruction counters for debug.

Parameters:
DATA_W, 32, ALU result and register data width
REG_ADDR_W, 4, register-file address width
CNT_W, 32, width of debug counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU output bundle valid
in_ready  output  1  stage can accept bundle
in_op_code  input  4  opcode issued to ALU
in_dest  input  REG_ADDR_W  destination register
in_result  input  DATA_W  ALU result
in_flags  input  4  ALU flags {N,Z,C,V}
in_cond  input  4  condition field
in_s  input  1  set-flags bit
flush  input  1  synchronous kill of held and incoming bundle
out_valid  output  1  write-back bundle valid
out_ready  input  1  register file or downstream accepts bundle
wb_en  output  1  register write enable, qualified by out_valid
wb_addr  output  REG_ADDR_W  register write address
wb_data  output  DATA_W  register write data
status_flags  output  4  architectural NZCV
retired_cnt  output  CNT_W  instructions with passed condition
skipped_cnt  output  CNT_W  instructions with failed condition

Behaviour:
- Reset, asynchronous, any cycle: out_valid, wb_en, wb_addr, wb_data, status_flags, retired_cnt and skipped_cnt all go to 0. A held bundle is discarded.
- Acceptance:
  - in_ready = !out_valid || out_ready (combinational).
  - A bundle is accepted when in_valid && in_ready && !flush.
  - Latency is 1 cycle: an accepted bundle appears on out_valid in the next cycle.
- Output holding: while out_valid && !out_ready, all out_* and wb_* signals hold stable.
- Condition evaluation:
  - Uses status_flags before this instruction's own update, evaluated combinationally at acceptance.
  - Codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - Codes continued: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Flag commit:
  - On acceptance with condition pass and (in_s || in_op_code==4'b1011 CMP), status_flags <= in_flags in the same edge.
  - The next accepted bundle therefore sees the updated flags with no forwarding path.
- Write enable:
  - wb_en = pass && in_op_code in 4'b0000..4'b1010.
  - CMP (1011) and 1100..1111 never write, because the ALU result is undriven or undefined for them.
  - wb_data = in_result; wb_addr = in_dest.
- Condition-failed bundles still occupy the stage and produce out_valid with wb_en=0, keeping retire order visible.
- Counters:
  - On acceptance, retired_cnt increments when the condition passes; otherwise skipped_cnt increments.
  - Both counters wrap modulo 2^CNT_W.
- Flush:
  - Next edge: out_valid <= 0; any same-cycle input is dropped, with no flag or counter update.
  - Flush overrides out_ready.
- Simultaneous output fire and new acceptance: the output register is replaced by the new bundle; no bubble.
- An X or z value on in_result for non-writing ops must never propagate to wb_data when wb_en=1.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode localparams (OP_ADD 0000 .. OP_CMP 1011, OP_NOP 1111);
  - condition-code localparams (COND_EQ .. COND_NV);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, `cond_check`: combinational, takes cond[3:0] and flags[3:0], returns pass. The decode stage reuses it later.

Test Plan:
- Reset then ADD: rst_n low mid-stream with out_valid=1 -> all outputs 0 immediately. After release, ADD dest=3, result=0x00000005, cond=AL, s=0 -> next cycle out_valid=1, wb_en=1, wb_addr=3, wb_data=5, status_flags=0000, retired_cnt=1.
- CMP then conditional move:
  - CMP with in_flags=0100 (Z), then COPY cond=EQ dest=2 result=0xA -> status_flags=0100 after CMP, CMP wb_en=0.
  - COPY wb_en=1, wb_addr=2.
  - Repeat with cond=NE -> wb_en=0, skipped_cnt=1.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, wb_data held constant. Release -> second bundle appears next cycle with no loss and no duplication.
- Back-to-back fire: out_ready=1, in_valid=1 for 4 bundles (results 1,2,3,4) -> out_valid continuous, wb_data 1,2,3,4 on consecutive cycles.
- Flush: held bundle plus in_valid with s=1 and in_flags=1000 during flush -> out_valid=0 next cycle, status_flags unchanged, counters unchanged.
- Condition table sweep: all 16 cond codes against flags 0000, 1001, 0110 and 0010 -> pass matches the table, including HI false when Z=1 and NV always false.
